rc4_crypt_stream: RTL and testbench

//  Consumer end of the RC4 keystream interface. Buffers keystream bytes in a

---
 rtl/rc4_crypt_stream.sv | 94 +++++++++
 tb/tb_rc4_crypt_stream.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/rc4_crypt_stream.sv
// rc4_crypt_stream: XORs a byte stream with buffered RC4 keystream, msg_len bytes per start, valid/ready on all ports.
module rc4_crypt_stream #(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] msg_len,
  input  logic             ks_valid,
  input  logic [7:0]       ks_data,
  output logic             ks_ready,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] byte_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, ks_cnt_q, ks_cnt_d, in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [7:0] out_data_q, out_data_d;
  logic out_valid_q, out_valid_d;
  logic accept, push, pop, out_hs;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = (state_q == IDLE && start) ? ((msg_len != '0) ? RUN : FIN) :
              (state_q == RUN && out_cnt_q == len_q) ? FIN :
              (state_q == FIN) ? IDLE : state_q;
  end
  always_comb begin
    busy      = state_q == RUN;
    done      = state_q == FIN;
    ks_ready  = busy && count_q != FULL && ks_cnt_q < len_q;
    in_ready  = busy && count_q != '0 && in_cnt_q < len_q && (!out_valid_q || out_ready);
    out_valid = out_valid_q;
    out_data  = out_data_q;
    byte_cnt  = out_cnt_q;
  end
  always_comb begin
    accept      = state_q == IDLE && start;
    push        = ks_valid && ks_ready;
    pop         = in_valid && in_ready;
    out_hs      = out_valid_q && out_ready;
    len_d       = accept ? msg_len : len_q;
    ks_cnt_d    = accept ? '0 : ks_cnt_q + LEN_W'(push);
    in_cnt_d    = accept ? '0 : in_cnt_q + LEN_W'(pop);
    out_cnt_d   = accept ? '0 : out_cnt_q + LEN_W'(out_hs);
    wr_ptr_d    = done ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d    = done ? '0 : rd_ptr_q + AW'(pop);
    count_d     = done ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
    out_valid_d = pop || (out_valid_q && !out_hs);
    out_data_d  = pop ? (in_data ^ mem_q[rd_ptr_q]) : out_data_q;
  end
  // Keystream storage carries no reset; only the pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= ks_data;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q       <= '0;
      ks_cnt_q    <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      len_q       <= len_d;
      ks_cnt_q    <= ks_cnt_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end
endmodule

// File: tb/tb_rc4_crypt_stream.sv
// tb_rc4_crypt_stream: directed vectors against a queue model of keystream, input and expected output bytes.
module tb_rc4_crypt_stream;
  localparam int D = 4;
  localparam int LW = 16;
  logic clk = 0, rst = 1, start = 0, ks_valid = 0, in_valid = 0, out_ready = 1;
  logic [LW-1:0] msg_len = '0;
  logic [7:0] ks_data = '0, in_data = '0;
  logic ks_ready, in_ready, out_valid, busy, done;
  logic [7:0] out_data;
  logic [LW-1:0] byte_cnt;
  rc4_crypt_stream #(.FIFO_DEPTH(D), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .msg_len(msg_len),
    .ks_valid(ks_valid), .ks_data(ks_data), .ks_ready(ks_ready),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done), .byte_cnt(byte_cnt));
  always #5 clk = ~clk;
  int checks = 0, passed = 0;
  logic [7:0] ks_q[$], in_q[$], exp_q[$];
  logic [7:0] ks1 [9] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7};
  logic [7:0] pt  [9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
  logic [7:0] ct  [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
  bit ks_hold = 0, stop = 0, done_seen = 0, prev_stall = 0;
  int cur_len = 0, n_ks = 0, n_in = 0, n_out = 0, n_done = 0, max_lvl = 0;
  logic [7:0] prev_data;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic feed_ks();
    bit hs;
    while (!stop) begin
      ks_valid = !ks_hold && ks_q.size() > 0;
      ks_data = ks_q.size() > 0 ? ks_q[0] : 8'h00;
      @(negedge clk);
      hs = ks_valid && ks_ready;
      cyc(1);
      if (hs) void'(ks_q.pop_front());
    end
    ks_valid = 0;
  endtask
  task automatic feed_in();
    bit hs;
    while (!stop) begin
      in_valid = in_q.size() > 0;
      in_data = in_q.size() > 0 ? in_q[0] : 8'h00;
      @(negedge clk);
      hs = in_valid && in_ready;
      cyc(1);
      if (hs) void'(in_q.pop_front());
    end
    in_valid = 0;
  endtask
  always @(negedge clk) begin
    if (rst) begin
      n_ks = 0; n_in = 0; n_out = 0; prev_stall = 0;
    end else begin
      if (start && !busy && !done) begin
        cur_len = int'(msg_len); n_ks = 0; n_in = 0; n_out = 0; n_done = 0;
      end
      if (prev_stall) chk("out_data_hold", out_data, prev_data);
      if (out_valid && !out_ready) chk("in_ready_stall", in_ready, 0);
      if (busy && n_ks == n_in) chk("in_ready_empty", in_ready, 0);
      if (busy && n_ks - n_in == D) chk("ks_ready_full", ks_ready, 0);
      if (busy && n_ks == cur_len) chk("ks_ready_len", ks_ready, 0);
      if (ks_valid && ks_ready) n_ks++;
      if (in_valid && in_ready) n_in++;
      if (n_ks - n_in > max_lvl) max_lvl = n_ks - n_in;
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) chk("unexpected_out", exp_q.size(), 1);
        else chk("out_data", out_data, exp_q.pop_front());
      end
      if (done) begin
        n_done++; done_seen = 1;
        chk("byte_cnt_done", byte_cnt, cur_len);
        chk("out_count", n_out, cur_len);
        chk("ks_count", n_ks, cur_len);
      end
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
    end
  end
  task automatic begin_msg(input int len);
    done_seen = 0; stop = 0;
    fork feed_ks(); feed_in(); join_none
    msg_len = LW'(len); start = 1;
    cyc(1);
    start = 0;
  endtask
  task automatic stop_feed();
    stop = 1; cyc(3); stop = 0;
    ks_q.delete(); in_q.delete();
  endtask
  task automatic end_msg();
    for (int i = 0; i < 200 && !done_seen; i++) cyc(1);
    chk("done_seen", done_seen, 1);
    stop_feed();
    chk("done_once", n_done, 1);
    chk("exp_drained", exp_q.size(), 0);
    chk("idle_after", {busy, done}, 0);
  endtask
  task automatic load_rand(input int nk, input int nd);
    logic [7:0] k, d;
    for (int i = 0; i < nk; i++) begin
      k = 8'($urandom_range(0, 255));
      ks_q.push_back(k);
      if (i < nd) begin
        d = 8'($urandom_range(0, 255));
        in_q.push_back(d);
        exp_q.push_back(d ^ k);
      end
    end
  endtask
  task automatic chk_zero(input string name);
    chk(name, {busy, done, ks_ready, in_ready, out_valid, out_data, byte_cnt}, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, checks so far %0d", checks);
    $fatal(1);
  end
  initial begin
    cyc(2);
    chk_zero("reset_state");
    rst = 0;
    cyc(1);
    for (int i = 0; i < 9; i++) begin ks_q.push_back(ks1[i]); in_q.push_back(pt[i]); exp_q.push_back(ct[i]); end
    begin_msg(9);
    end_msg();
    chk("t1_byte_cnt", byte_cnt, 9);
    for (int i = 0; i < 9; i++) begin ks_q.push_back(ks1[i]); in_q.push_back(ct[i]); exp_q.push_back(pt[i]); end
    begin_msg(9);
    cyc(3);
    msg_len = LW'(3); start = 1;
    cyc(1);
    start = 0;
    end_msg();
    chk("t2_byte_cnt", byte_cnt, 9);
    load_rand(12, 12);
    max_lvl = 0;
    begin_msg(12);
    for (int i = 0; i < 100 && n_out < 2; i++) cyc(1);
    out_ready = 0;
    cyc(5);
    chk("t3_ks_ready_full", ks_ready, 0);
    chk("t3_in_ready_stall", in_ready, 0);
    out_ready = 1;
    end_msg();
    chk("t3_fifo_filled", max_lvl, D);
    load_rand(9, 6);
    ks_hold = 1;
    begin_msg(6);
    cyc(6);
    chk("t4_starve_in_ready", in_ready, 0);
    ks_hold = 0;
    end_msg();
    chk("t4_ks_ready_off", ks_ready, 0);
    load_rand(4, 4);
    exp_q.delete();
    begin_msg(0);
    @(negedge clk);
    chk("t5_done_pulse", done, 1);
    @(negedge clk);
    chk("t5_done_end", done, 0);
    cyc(3);
    chk("t5_no_hs", n_ks + n_in + n_out, 0);
    stop_feed();
    load_rand(9, 9);
    begin_msg(9);
    for (int i = 0; i < 100 && n_out < 3; i++) cyc(1);
    chk("t6_three_out", n_out, 3);
    rst = 1;
    #1;
    chk_zero("t6_async_reset");
    stop_feed();
    exp_q.delete();
    rst = 0;
    cyc(1);
    load_rand(9, 9);
    begin_msg(9);
    end_msg();
    chk("t6_byte_cnt", byte_cnt, 9);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
